cordic_hyp_sched: RTL

CORDIC_HYP_SCHED -- requirements
Module: cordic_hyp_sched

---
 rtl/cordic_hyp_sched_if.sv | 46 ++++
 rtl/cordic_hyp_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cordic_hyp_sched_if.sv
// Purpose: bundles the requester, cordic_hyp and status signals of cordic_hyp_sched.
// Latency: none; this is wiring only.
// Backpressure: carried by gnt (requester side) and full; the cordic side has none.
// Ports (by group):
//   requester : req, req_func, req_a (to scheduler); gnt, rsp_valid, rsp_f (from scheduler)
//   cordic    : c_start, c_func, c_a (from scheduler); c_valid, c_f (to scheduler)
//   status    : inflight, full, err (from scheduler)
// master = environment (requesters + cordic pipeline), slave = the scheduler.
interface cordic_hyp_sched_if #(
  parameter int NREQ  = 4,
  parameter int W     = 12,
  parameter int DEPTH = 16
);
  localparam int DW = 2 * W;
  localparam int CW = $clog2(DEPTH) + 1;

  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_func;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ-1:0]    gnt;

  // cordic_hyp side
  logic               c_start;
  logic               c_func;
  logic [DW-1:0]      c_a;
  logic               c_valid;
  logic [DW-1:0]      c_f;

  // Results and status
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_f;
  logic [CW-1:0]      inflight;
  logic               full;
  logic               err;

  modport master (
    output req, req_func, req_a, c_valid, c_f,
    input  gnt, c_start, c_func, c_a, rsp_valid, rsp_f, inflight, full, err
  );

  modport slave (
    input  req, req_func, req_a, c_valid, c_f,
    output gnt, c_start, c_func, c_a, rsp_valid, rsp_f, inflight, full, err
  );
endinterface

// File: rtl/cordic_hyp_sched.sv
// Purpose: round-robin scheduler sharing one in-order cordic_hyp pipeline among NREQ requesters.
// Latency: grant is combinational; operands reach the cordic 1 cycle later; a result reaches its owner 1 cycle after c_valid.
// Backpressure: gnt is withheld while DEPTH operations are in flight; the cordic side is never stalled.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - slave modport of cordic_hyp_sched_if:
//          req/req_func/req_a in, gnt out (combinational one-hot)
//          c_start/c_func/c_a out (registered), c_valid/c_f in
//          rsp_valid/rsp_f out (registered), inflight/full/err out
module cordic_hyp_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cordic_hyp_sched_if.slave bus
);
  localparam int DW = 2 * W;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Round-robin pointer: the requester index scanned first.
  logic [PW-1:0]   ptr;

  // Arbitration results (combinational)
  logic            cand;
  logic            grant;
  logic [PW-1:0]   win;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   scan_idx;
  logic [NREQ-1:0] gnt_c;
  logic            sel_func;
  logic [DW-1:0]   sel_a;

  // Tag FIFO: owner index of every issued operation, in issue order.
  logic [PW-1:0]   tag_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   inflight_q;
  logic            full_c;
  logic            empty_c;
  logic            pop;

  // Registered outputs
  logic            c_start_q;
  logic            c_func_q;
  logic [DW-1:0]   c_a_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_f_q;
  logic            err_q;

  assign full_c  = (inflight_q == CW'(DEPTH));
  assign empty_c = (inflight_q == '0);

  // A result with no tag outstanding is a protocol error, not a pop.
  assign pop = bus.c_valid && !empty_c;

  // Scan ptr, ptr+1, ... modulo NREQ; the first asserted request wins.
  // The index is wrapped by subtraction so NREQ need not be a power of two.
  always_comb begin
    cand     = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!cand && bus.req[scan_idx]) begin
        cand = 1'b1;
        win  = scan_idx;
      end
    end
  end

  // No issue while full, even if a result pops this same cycle: the slot
  // only becomes visible once inflight has actually dropped.
  assign grant = cand && !full_c && !rst;
  assign gnt_c = grant ? (NREQ'(1) << win) : '0;

  // Operand mux for the winning requester.
  always_comb begin
    sel_func = 1'b0;
    sel_a    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        sel_func = bus.req_func[k];
        sel_a    = bus.req_a[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight_q  <= '0;
      c_start_q   <= 1'b0;
      c_func_q    <= 1'b0;
      c_a_q       <= '0;
      rsp_valid_q <= '0;
      rsp_f_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      c_start_q <= grant;
      if (grant) begin
        ptr      <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
        c_func_q <= sel_func;
        c_a_q    <= sel_a;
        wr_ptr   <= wr_ptr + AW'(1);
      end

      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        rsp_valid_q <= NREQ'(1) << tag_mem[rd_ptr];
        rsp_f_q     <= bus.c_f;
      end else begin
        rsp_valid_q <= '0;
      end

      if (bus.c_valid && empty_c) begin
        err_q <= 1'b1;
      end

      // Push and pop together leave the count unchanged.
      case ({grant, pop})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read behind wr_ptr.
  always_ff @(posedge clk) begin
    if (!rst && grant) begin
      tag_mem[wr_ptr] <= win;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.c_start   = c_start_q;
  assign bus.c_func    = c_func_q;
  assign bus.c_a       = c_a_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.inflight  = inflight_q;
  assign bus.full      = full_c;
  assign bus.err       = err_q;
endmodule
